mem_port_arbiter: RTL

//  Shares one single-port unified memory between instruction fetch (IF) and

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between the instruction-fetch (IF)
// and data-memory (DM) requesters. Only one transaction is in flight at a
// time. DM has priority. A starvation counter bounds how many DM grants IF can
// lose in a row.
//
// Ports
//   i_clk, i_reset_n               clock, asynchronous active-low reset
//   i_if_req/i_if_addr             IF request; held until o_if_gnt
//   o_if_gnt                       IF request accepted this cycle
//   o_if_rvalid/o_if_rdata         IF read response pulse and data
//   i_dm_req/we/addr/wdata/be      DM request; held until o_dm_gnt
//   o_dm_gnt                       DM request accepted this cycle
//   o_dm_rvalid/o_dm_rdata         DM completion pulse; data on reads, 0 on writes
//   o_mem_en/we/addr/wdata/be      memory command, one strobe per grant
//   i_mem_rdata                    memory read data, MEM_LAT cycles after strobe
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,

   input  logic                  i_if_req,
   input  logic [ADDR_W-1:0]     i_if_addr,
   output logic                  o_if_gnt,
   output logic                  o_if_rvalid,
   output logic [DATA_W-1:0]     o_if_rdata,

   input  logic                  i_dm_req,
   input  logic                  i_dm_we,
   input  logic [ADDR_W-1:0]     i_dm_addr,
   input  logic [DATA_W-1:0]     i_dm_wdata,
   input  logic [DATA_W/8-1:0]   i_dm_be,
   output logic                  o_dm_gnt,
   output logic                  o_dm_rvalid,
   output logic [DATA_W-1:0]     o_dm_rdata,

   output logic                  o_mem_en,
   output logic                  o_mem_we,
   output logic [ADDR_W-1:0]     o_mem_addr,
   output logic [DATA_W-1:0]     o_mem_wdata,
   output logic [DATA_W/8-1:0]   o_mem_be,
   input  logic [DATA_W-1:0]     i_mem_rdata
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned LAT_W = 3;
   localparam int unsigned STV_W = 4;

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);
   localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

   // Elaboration-time parameter range checks
   if ((MEM_LAT < 1) || (MEM_LAT > 7)) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be 1..7");
   end
   if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
      $error("mem_port_arbiter: STARVE_MAX must be 1..15");
   end
   if ((DATA_W % 8) != 0) begin : g_bad_data_w
      $error("mem_port_arbiter: DATA_W must be a multiple of 8");
   end

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   state_e              state_q,  state_d;
   logic [LAT_W-1:0]    lat_q,    lat_d;
   logic [STV_W-1:0]    starve_q, starve_d;
   owner_e              owner_q,  owner_d;
   logic                wr_q,     wr_d;

   logic                resp_c;
   logic                window_c;
   logic                if_pri_c;
   logic                if_gnt_c;
   logic                dm_gnt_c;

   // Response cycle and grant window; the window also covers the response
   // cycle so a new command can issue back-to-back with the completing one.
   always_comb begin
      resp_c   = (state_q == ST_BUSY) && (lat_q == LAT_ONE);
      window_c = i_reset_n && ((state_q == ST_IDLE) || resp_c);
   end

   // Arbitration: DM wins unless IF has waited through STARVE_MAX DM grants.
   always_comb begin
      if_pri_c = i_if_req && (starve_q == STV_MAX);
      if_gnt_c = window_c && i_if_req && (!i_dm_req || if_pri_c);
      dm_gnt_c = window_c && i_dm_req && !if_pri_c;
   end

   // Memory command follows the granted requester in the same cycle
   always_comb begin
      o_if_gnt    = if_gnt_c;
      o_dm_gnt    = dm_gnt_c;
      o_mem_en    = if_gnt_c || dm_gnt_c;
      o_mem_we    = dm_gnt_c && i_dm_we;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_be    = '0;
      if (if_gnt_c) begin
         o_mem_addr = i_if_addr;
      end else if (dm_gnt_c) begin
         o_mem_addr  = i_dm_addr;
         o_mem_wdata = i_dm_wdata;
         o_mem_be    = BE_W'(i_dm_be);
      end
   end

   // Response routing; read data is a pass-through from the memory macro
   always_comb begin
      o_if_rvalid = resp_c && (owner_q == OWN_IF);
      o_dm_rvalid = resp_c && (owner_q == OWN_DM);
      o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
      o_dm_rdata  = (o_dm_rvalid && !wr_q) ? i_mem_rdata : '0;
   end

   // Next-state: transaction tracking and starvation counter
   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      owner_d  = owner_q;
      wr_d     = wr_q;
      starve_d = starve_q;

      if (if_gnt_c || dm_gnt_c) begin
         state_d = ST_BUSY;
         lat_d   = LAT_LOAD;
         owner_d = dm_gnt_c ? OWN_DM : OWN_IF;
         wr_d    = dm_gnt_c && i_dm_we;
      end else if (state_q == ST_BUSY) begin
         if (resp_c) begin
            state_d = ST_IDLE;
            lat_d   = '0;
         end else begin
            lat_d = lat_q - LAT_ONE;
         end
      end

      // Counts DM wins while IF is waiting; any IF grant or idle IF clears it
      if (if_gnt_c || !i_if_req) begin
         starve_d = '0;
      end else if (dm_gnt_c && (starve_q != STV_MAX)) begin
         starve_d = starve_q + STV_ONE;
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= ST_IDLE;
         lat_q    <= '0;
         starve_q <= '0;
         owner_q  <= OWN_IF;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         starve_q <= starve_d;
         owner_q  <= owner_d;
         wr_q     <= wr_d;
      end
   end

endmodule
